// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage.
//   common : address/word typedefs and the default reset PC.
//   pipes  : pipeline-register payloads and the fetch state encoding.
package common;
    typedef logic [63:0] addr_t;
    typedef logic [31:0] u32;

    localparam addr_t PC_RESET_DEFAULT = 64'h8000_0000;
endpackage

package pipes;
    import common::*;

    // Fetch-side exception info handed to decode with the instruction.
    typedef struct packed {
        logic       error;
        logic [3:0] code;   // 0 = instruction address misaligned
    } fetch_csr_t;

    typedef struct packed {
        logic       valid;
        addr_t      pc;
        u32         raw_instr;
        fetch_csr_t csr;
    } fetch_data_t;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DISCARD
    } fetch_state_t;
endpackage

// File: rtl/fetch_if.sv
// Instruction bus between fetch (master) and the instruction memory (slave).
//   ireq_valid/ireq_addr       : request, held until iresp_data_ok
//   iresp_data_ok/iresp_data   : response, may arrive in the request cycle
interface fetch_if;
    import common::*;

    logic  ireq_valid;
    addr_t ireq_addr;
    logic  iresp_data_ok;
    u32    iresp_data;

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_data_ok, iresp_data
    );

    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_data_ok, iresp_data
    );
endinterface

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched {pc, instr} while decode stalls.
//   clk, reset       : clock, synchronous active-high reset
//   load             : capture in_pc/in_instr
//   drain            : entry consumed, mark empty
//   flush            : discard the entry (redirect/branch); wins over load
//   valid/pc/instr   : stored entry
module fetch_skid
    import common::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  logic  drain,
    input  logic  flush,
    input  addr_t in_pc,
    input  u32    in_instr,
    output logic  valid,
    output addr_t pc,
    output u32    instr
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= in_pc;
            instr <= in_instr;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues hold-until-data_ok requests,
// and presents the fetched instruction to decode in the dataF register.
//   clk, reset              : clock, synchronous active-high reset
//   ibus                    : instruction bus (master side)
//   branch, PCbranch        : decode redirect for the instruction in dataF
//   redirect, redirect_pc   : trap/mret redirect, highest priority
//   stallF                  : decode is not consuming dataF this cycle
//   dataF                   : registered {valid, pc, raw_instr, csr}
module fetch
    import common::*;
    import pipes::*;
#(
    parameter addr_t PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    fetch_if.master     ibus,
    input  logic        branch,
    input  addr_t       PCbranch,
    input  logic        redirect,
    input  addr_t       redirect_pc,
    input  logic        stallF,
    output fetch_data_t dataF
);

    fetch_state_t state, state_n;
    addr_t        pc, pc_n;
    addr_t        disc_addr, disc_n;   // address of the wrong-path request still owed
    fetch_data_t  data_n;

    logic  skid_load, skid_drain, skid_flush;
    logic  skid_valid;
    addr_t skid_pc;
    u32    skid_instr;

    logic req_valid, owed, take, slot_free, br_take, misaligned;

    assign take       = dataF.valid & ~stallF;
    assign slot_free  = ~dataF.valid | take;
    assign br_take    = branch & take;
    assign misaligned = pc[1:0] != 2'b00;

    fetch_skid u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load),
        .drain    (skid_drain),
        .flush    (skid_flush),
        .in_pc    (pc),
        .in_instr (ibus.iresp_data),
        .valid    (skid_valid),
        .pc       (skid_pc),
        .instr    (skid_instr)
    );

    // In DISCARD the pc already points at the new target; the bus must keep
    // seeing the address of the request it still owes.
    assign ibus.ireq_valid = req_valid & ~reset;
    assign ibus.ireq_addr  = (state == DISCARD) ? disc_addr : pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= PC_RESET;
            dataF     <= '0;
            disc_addr <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            dataF     <= data_n;
            disc_addr <= disc_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        data_n     = dataF;
        disc_n     = disc_addr;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_flush = 1'b0;

        case (state)
            FETCH:   req_valid = ~misaligned;
            HOLD:    req_valid = 1'b0;
            DISCARD: req_valid = 1'b1;
            default: req_valid = 1'b0;
        endcase
        owed = req_valid & ~ibus.iresp_data_ok;

        if (take)
            data_n.valid = 1'b0;

        if (redirect || br_take) begin
            // Any response arriving this cycle belongs to the wrong path.
            pc_n         = redirect ? redirect_pc : PCbranch;
            data_n.valid = 1'b0;
            skid_flush   = 1'b1;
            if (owed) begin
                state_n = DISCARD;
                if (state != DISCARD)
                    disc_n = pc;
            end else begin
                state_n = FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (misaligned) begin
                        // Re-present the fault every time the slot frees;
                        // pc stays put until a redirect.
                        if (slot_free) begin
                            data_n.valid     = 1'b1;
                            data_n.pc        = pc;
                            data_n.raw_instr = '0;
                            data_n.csr.error = 1'b1;
                            data_n.csr.code  = 4'd0;
                        end
                    end else if (ibus.iresp_data_ok) begin
                        pc_n = pc + 64'd4;
                        if (slot_free) begin
                            data_n.valid     = 1'b1;
                            data_n.pc        = pc;
                            data_n.raw_instr = ibus.iresp_data;
                            data_n.csr       = '0;
                        end else begin
                            skid_load = 1'b1;
                            state_n   = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (slot_free && skid_valid) begin
                        data_n.valid     = 1'b1;
                        data_n.pc        = skid_pc;
                        data_n.raw_instr = skid_instr;
                        data_n.csr       = '0;
                        skid_drain       = 1'b1;
                        state_n          = FETCH;
                    end
                end
                DISCARD: begin
                    if (ibus.iresp_data_ok)
                        state_n = FETCH;
                end
                default: state_n = FETCH;
            endcase
        end
    end

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the 64-bit RISC-V pipeline: owns the PC, drives the instruction bus with a hold-until-`data_ok` handshake, and presents the fetched instruction to decode as a registered `fetch_data_t`. Redirects from decode branches and from trap/mret are absorbed here. Wrong-path responses still owed by the bus are discarded. A one-entry skid buffer keeps fetch running while decode stalls.

## Interface
- `PC_RESET`, default 64'h8000_0000: PC loaded on reset.
- `clk`  in  1: clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `ireq_valid`  out  1: instruction request valid.
- `ireq_addr`  out  64: request address; stable while `ireq_valid` and not `iresp_data_ok`.
- `iresp_data_ok`  in  1: response valid this cycle; may arrive in the same cycle as the request.
- `iresp_data`  in  32: instruction word, valid with `iresp_data_ok`.
- `branch`  in  1: decode redirect for the instruction currently in `dataF`.
- `PCbranch`  in  64: branch/jump target.
- `redirect`  in  1: trap/mret redirect from commit; highest priority.
- `redirect_pc`  in  64: trap vector or mepc.
- `stallF`  in  1: decode does not consume `dataF` this cycle.
- `dataF`  out  `fetch_data_t`: registered {valid, pc, raw_instr, csr}.

## Operation
- The state machine `fetch_state_t` has three states: FETCH, HOLD, DISCARD.
- Consume condition: `take = dataF.valid & ~stallF`. A slot is free when `~dataF.valid | take`.
- Event priority: `reset` > `redirect` > (`branch` & `take`) > normal. `branch` is ignored while `stallF`=1.
- **FETCH**
  - Assert `ireq_valid` with `ireq_addr = pc`.
  - On `data_ok` with a free slot: load `dataF` with {1, pc, iresp_data, csr='0}. Then `pc <= pc+4`.
  - On `data_ok` with no free slot: capture {pc, data} into the skid buffer, `pc <= pc+4`, go to HOLD.
- **HOLD**
  - `ireq_valid`=0.
  - When the slot frees, move the skid entry into `dataF` and go to FETCH.
- **DISCARD**
  - Keep `ireq_valid`=1 and keep the old address stable.
  - On `data_ok`, drop the data and go to FETCH, which requests the already-updated `pc`.
- **Misaligned PC** (`pc[1:0]` != 0) in FETCH:
  - No bus request is made.
  - When the slot is free, load `dataF` with {1, pc, 32'h0, csr.error=1, csr.code=0}.
  - Then stay in FETCH with `pc` unchanged, until a redirect arrives.
- **Redirect** (`redirect`=1):
  - `pc <= redirect_pc`; `dataF.valid <= 0`; the skid buffer is cleared.
  - If a request is outstanding without `data_ok` this cycle, go to DISCARD. Otherwise go to FETCH.
- **Branch with take:**
  - `pc <= PCbranch`; the skid buffer is cleared; `dataF.valid <= 0`.
  - Outstanding request handling is the same as for redirect.
  - A `data_ok` arriving in the same cycle is dropped.
- Address arithmetic is 64-bit modulo 2^64; `pc+4` wraps silently.

## Timing
- Reset values: `pc`=PC_RESET, state=FETCH, `dataF`='0, skid buffer empty.
- `ireq_valid`=0 during the reset cycle. The first request goes out in the cycle after `reset` deasserts.
- Latency is one cycle from `data_ok` to `dataF.valid`.
- With a zero-wait bus (combinational `data_ok`), throughput is one instruction per cycle.
- Redirect or branch at cycle n: the request for the new PC issues at n+1 if no response is owed. If a response is owed, it issues in the cycle after the owed `data_ok`.
- `reset` asserted mid-transaction abandons the outstanding response. The bus must tolerate this.

## Structure
- `fetch_state_t` goes in `pipes`. `fetch_data_t` already lives in `pipes`.
- `PC_RESET`'s default and the `addr_t`/`u32` typedefs come from `common`.
- The one-entry skid buffer is a natural sub-module: `fetch_skid`, with {valid, pc, instr}, plus load, drain and flush controls.

## Test plan
- **Reset then zero-wait bus:** requests go to 8000_0000, then 8000_0004, then 8000_0008. `dataF.pc` follows one cycle later, with `valid`=1 every cycle.
- **Bus latency 3 cycles:** `ireq_addr` is held at 8000_0000 for 3 cycles. `dataF` loads raw_instr 0x00000013 in the cycle after `data_ok`.
- **`stallF`=1 for 4 cycles with zero-wait bus:**
  - `dataF` is held.
  - The instruction at pc+4 goes to the skid buffer (HOLD) and no request is made.
  - After release, the sequence continues with no duplicated or lost PC.
- **Branch during an outstanding 2-cycle request:** `branch`=1, `PCbranch`=8000_0100.
  - The old address is held until `data_ok`, and that data is dropped.
  - The next request is 8000_0100.
  - `dataF.valid`=0 in between.
- **`redirect` and `branch` asserted together:** `redirect_pc`=8000_0200 wins and `PCbranch` is ignored.
- **Redirect to 8000_0102:**
  - No bus request is made.
  - `dataF` = {valid=1, pc=8000_0102, error=1, code=0}.
  - This repeats until the next redirect.
